// File: rtl/adda_pkg.sv
// Shared types and constants for the ADDA capture path.
package adda_pkg;

  // Native AD9280 sample width.
  localparam int unsigned ADC_DATA_W = 8;

  // Encoding of i_trig_rising.
  localparam logic TRIG_RISING  = 1'b1;
  localparam logic TRIG_FALLING = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StPreFill,
    StWaitTrig,
    StPostFill,
    StReadout
  } cap_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (maps to ECP5 EBR).
module capture_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write port; contents are never cleared.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port, one cycle latency.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      rdata_q <= mem[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/adc_capture_trigger.sv
// Circular ADC history with level/forced trigger; freezes a pre/post window and streams it out.
module adc_capture_trigger
  import adda_pkg::*;
#(
  parameter int unsigned DATA_W     = ADC_DATA_W,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned PRETRIG    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_sample_valid,
  input  logic [DATA_W-1:0]     i_sample,
  input  logic                  i_arm,
  input  logic                  i_abort,
  input  logic                  i_force_trig,
  input  logic [DATA_W-1:0]     i_trig_level,
  input  logic                  i_trig_rising,
  output logic                  o_armed,
  output logic                  o_triggered,
  output logic [DEPTH_LOG2-1:0] o_trig_addr,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_last,
  input  logic                  i_rd_ready
);

  localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
  localparam int unsigned POST_LEN = DEPTH - PRETRIG;
  localparam int unsigned CW       = DEPTH_LOG2 + 1;

  localparam logic [DEPTH_LOG2-1:0] PRETRIG_A = DEPTH_LOG2'(PRETRIG);
  localparam logic [DEPTH_LOG2-1:0] RD_LAST   = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [CW-1:0]         PRE_LAST  = CW'(PRETRIG - 1);
  localparam logic [CW-1:0]         POST_LAST = CW'(POST_LEN - 1);
  localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);

  cap_state_e state_q, state_d;

  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         fill_cnt_q, fill_cnt_d;   // pre-count, then post-count
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d; // RAM reads issued in readout
  logic [DEPTH_LOG2-1:0] rd_cnt_q, rd_cnt_d;       // words handed to consumer
  logic                  inflight_q, inflight_d;   // RAM read data arrives this cycle
  logic                  out_vld_q, out_vld_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0]     skid_data_q, skid_data_d;
  logic [DATA_W-1:0]     prev_q, prev_d;
  logic                  prev_vld_q, prev_vld_d;
  logic                  force_q, force_d;
  logic                  trig_q, trig_d;
  logic [DEPTH_LOG2-1:0] trig_addr_q, trig_addr_d;

  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  logic       rise_hit, fall_hit, edge_hit, trig_hit;
  logic       pop, issue_ok, go_idle;
  logic [1:0] held;

  capture_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(DEPTH_LOG2)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (ram_we),
    .i_waddr(wptr_q),
    .i_wdata(i_sample),
    .i_re   (ram_re),
    .i_raddr(rptr_q),
    .o_rdata(ram_rdata)
  );

  // Edge detection is meaningless until a previous sample exists since arm.
  assign rise_hit = prev_vld_q && (prev_q < i_trig_level) && (i_sample >= i_trig_level);
  assign fall_hit = prev_vld_q && (prev_q >= i_trig_level) && (i_sample < i_trig_level);
  assign edge_hit = (i_trig_rising == TRIG_RISING) ? rise_hit : fall_hit;
  assign trig_hit = force_q || edge_hit;

  // Readout: words held in output reg, skid reg and in the RAM pipe never exceed two.
  assign pop      = out_vld_q && i_rd_ready;
  assign held     = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(inflight_q);
  assign issue_ok = (issue_cnt_q != DEPTH_C) && (held < (2'd2 + 2'(pop)));

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    fill_cnt_d  = fill_cnt_q;
    issue_cnt_d = issue_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    inflight_d  = 1'b0;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    force_d     = force_q;
    trig_d      = trig_q;
    trig_addr_d = trig_addr_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    go_idle     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_arm && !i_abort) begin
          state_d    = StPreFill;
          fill_cnt_d = '0;
          prev_vld_d = 1'b0;
          force_d    = 1'b0;
        end
      end

      StPreFill: begin
        if (i_force_trig) force_d = 1'b1;
        if (i_sample_valid) begin
          ram_we     = 1'b1;
          wptr_d     = wptr_q + 1'b1;
          fill_cnt_d = fill_cnt_q + 1'b1;
          prev_d     = i_sample;
          prev_vld_d = 1'b1;
          if (fill_cnt_q == PRE_LAST) begin
            state_d    = StWaitTrig;
            fill_cnt_d = '0;
          end
        end
      end

      StWaitTrig: begin
        if (i_force_trig) force_d = 1'b1;
        if (i_sample_valid) begin
          ram_we     = 1'b1;
          wptr_d     = wptr_q + 1'b1;
          prev_d     = i_sample;
          prev_vld_d = 1'b1;
          if (trig_hit) begin
            trig_d      = 1'b1;
            trig_addr_d = wptr_q;
            force_d     = 1'b0;
            fill_cnt_d  = CW'(1);
            // With a single post sample the trigger itself completes the window.
            if (POST_LEN == 1) begin
              state_d     = StReadout;
              rptr_d      = wptr_q - PRETRIG_A;
              issue_cnt_d = '0;
              rd_cnt_d    = '0;
            end else begin
              state_d = StPostFill;
            end
          end
        end
      end

      StPostFill: begin
        if (i_sample_valid) begin
          ram_we     = 1'b1;
          wptr_d     = wptr_q + 1'b1;
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == POST_LAST) begin
            state_d     = StReadout;
            rptr_d      = trig_addr_q - PRETRIG_A;
            issue_cnt_d = '0;
            rd_cnt_d    = '0;
          end
        end
      end

      StReadout: begin
        if (issue_ok) begin
          ram_re      = 1'b1;
          rptr_d      = rptr_q + 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
          inflight_d  = 1'b1;
        end
        if (pop) begin
          out_vld_d  = skid_vld_q;
          out_data_d = skid_data_q;
          skid_vld_d = 1'b0;
          rd_cnt_d   = rd_cnt_q + 1'b1;
        end
        // Returning RAM data fills the output first, else parks in the skid.
        if (inflight_q) begin
          if (!out_vld_d) begin
            out_vld_d  = 1'b1;
            out_data_d = ram_rdata;
          end else begin
            skid_vld_d  = 1'b1;
            skid_data_d = ram_rdata;
          end
        end
        if (pop && (rd_cnt_q == RD_LAST)) go_idle = 1'b1;
      end

      default: state_d = StIdle;
    endcase

    // Abort overrides anything else happening this cycle, including writes.
    if (go_idle || (i_abort && (state_q != StIdle))) begin
      state_d     = StIdle;
      wptr_d      = wptr_q;
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      inflight_d  = 1'b0;
      out_vld_d   = 1'b0;
      out_data_d  = '0;
      skid_vld_d  = 1'b0;
      force_d     = 1'b0;
      trig_d      = 1'b0;
      trig_addr_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fill_cnt_q  <= '0;
      issue_cnt_q <= '0;
      rd_cnt_q    <= '0;
      inflight_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      force_q     <= 1'b0;
      trig_q      <= 1'b0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fill_cnt_q  <= fill_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      inflight_q  <= inflight_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      force_q     <= force_d;
      trig_q      <= trig_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  assign o_armed     = (state_q == StPreFill) || (state_q == StWaitTrig);
  assign o_triggered = trig_q;
  assign o_trig_addr = trig_addr_q;
  assign o_rd_data   = out_data_q;
  assign o_rd_valid  = out_vld_q;
  assign o_rd_last   = out_vld_q && (rd_cnt_q == RD_LAST);

endmodule

// File: tb/tb_adc_capture_trigger.sv
// Self-checking bench for adc_capture_trigger (DEPTH 16, PRETRIG 4), scoreboard on readout.
module tb_adc_capture_trigger;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned PRETRIG    = 4;
  localparam int unsigned DEPTH      = 16;

  logic                  i_clk;
  logic                  i_reset_n;
  logic                  i_sample_valid;
  logic [DATA_W-1:0]     i_sample;
  logic                  i_arm;
  logic                  i_abort;
  logic                  i_force_trig;
  logic [DATA_W-1:0]     i_trig_level;
  logic                  i_trig_rising;
  logic                  o_armed;
  logic                  o_triggered;
  logic [DEPTH_LOG2-1:0] o_trig_addr;
  logic [DATA_W-1:0]     o_rd_data;
  logic                  o_rd_valid;
  logic                  o_rd_last;
  logic                  i_rd_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int mon_cyc  = 0;
  int first_cyc, last_cyc;
  bit rnd_ready = 0;

  // Expected readout words, {last, data}.
  logic [DATA_W:0] exp_q[$];

  adc_capture_trigger #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .PRETRIG   (PRETRIG)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_sample_valid(i_sample_valid),
    .i_sample      (i_sample),
    .i_arm         (i_arm),
    .i_abort       (i_abort),
    .i_force_trig  (i_force_trig),
    .i_trig_level  (i_trig_level),
    .i_trig_rising (i_trig_rising),
    .o_armed       (o_armed),
    .o_triggered   (o_triggered),
    .o_trig_addr   (o_trig_addr),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .o_rd_last     (o_rd_last),
    .i_rd_ready    (i_rd_ready)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Readout monitor: pops the scoreboard on each handshake and checks hold-while-stalled.
  initial begin
    bit              stall;
    logic [DATA_W-1:0] stall_data;
    logic [DATA_W:0]   exp;
    stall = 0;
    stall_data = '0;
    forever begin
      @(negedge i_clk);
      mon_cyc++;
      if (i_reset_n !== 1'b1) begin
        stall = 0;
      end else begin
        if (stall) begin
          n_checks++;
          if (o_rd_valid !== 1'b1 || o_rd_data !== stall_data) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                     o_rd_valid, o_rd_data, stall_data);
          end
        end
        if (o_rd_valid === 1'b1 && i_rd_ready === 1'b1) begin
          hs_cnt++;
          if (hs_cnt == 1) first_cyc = mon_cyc;
          last_cyc = mon_cyc;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL readout_extra: got data=%h last=%b, required no word",
                     o_rd_data, o_rd_last);
          end else begin
            exp = exp_q.pop_front();
            if ({o_rd_last, o_rd_data} !== exp) begin
              n_fail++;
              $display("FAIL readout_word %0d: got last=%b data=%h, required last=%b data=%h",
                       hs_cnt, o_rd_last, o_rd_data, exp[DATA_W], exp[DATA_W-1:0]);
            end
          end
        end
        stall      = (o_rd_valid === 1'b1) && (i_rd_ready !== 1'b1);
        stall_data = o_rd_data;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (rnd_ready) i_rd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_inputs();
    i_sample_valid = 1'b0;
    i_sample       = '0;
    i_arm          = 1'b0;
    i_abort        = 1'b0;
    i_force_trig   = 1'b0;
  endtask

  task automatic apply_reset();
    i_reset_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    repeat (2) tick();
    i_reset_n = 1'b1;
    tick();
  endtask

  task automatic arm_capture(input logic [DATA_W-1:0] level, input logic rising);
    i_trig_level  = level;
    i_trig_rising = rising;
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
  endtask

  task automatic feed(input logic [DATA_W-1:0] v);
    i_sample_valid = 1'b1;
    i_sample       = v;
    tick();
    i_sample_valid = 1'b0;
  endtask

  task automatic feed_ramp(input int start, input int n);
    for (int i = 0; i < n; i++) feed(8'(start + i));
  endtask

  // Expected window of 16 consecutive ramp values starting at first.
  task automatic push_ramp_window(input int first);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), 8'(first + i)});
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && o_rd_valid === 1'b0) done = 1;
      else tick();
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
    end
    n_checks++;
    if (hs_cnt != DEPTH) begin
      n_fail++;
      $display("FAIL %s_handshakes: got %0d, required %0d", name, hs_cnt, DEPTH);
    end
    n_checks++;
    if ({o_armed, o_triggered, o_rd_valid, o_rd_last} !== 4'b0) begin
      n_fail++;
      $display("FAIL %s_idle_after: got armed=%b trig=%b valid=%b last=%b, required 0000",
               name, o_armed, o_triggered, o_rd_valid, o_rd_last);
    end
    tick();
  endtask

  task automatic test_reset();
    i_reset_n     = 1'b0;
    i_rd_ready    = 1'b1;
    i_trig_level  = '0;
    i_trig_rising = 1'b1;
    idle_inputs();
    @(negedge i_clk);
    n_checks++;
    if ({o_armed, o_triggered, o_trig_addr, o_rd_data, o_rd_valid, o_rd_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got armed=%b trig=%b addr=%h data=%h valid=%b last=%b, required 0",
               o_armed, o_triggered, o_trig_addr, o_rd_data, o_rd_valid, o_rd_last);
    end
    tick();
    i_reset_n = 1'b1;
    tick();
    // Arm and abort together in IDLE: abort wins.
    i_arm   = 1'b1;
    i_abort = 1'b1;
    tick();
    idle_inputs();
    @(negedge i_clk);
    n_checks++;
    if (o_armed !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_abort_idle: got armed=%b, required 0", o_armed);
    end
  endtask

  task automatic test_rising();
    apply_reset();
    hs_cnt = 0;
    arm_capture(8'd10, 1'b1);
    @(negedge i_clk);
    n_checks++;
    if (o_armed !== 1'b1) begin
      n_fail++;
      $display("FAIL rising_armed: got %b, required 1", o_armed);
    end
    push_ramp_window(6);
    feed_ramp(0, 10);
    @(negedge i_clk);
    n_checks++;
    if (o_triggered !== 1'b0) begin
      n_fail++;
      $display("FAIL rising_early: got triggered=%b, required 0", o_triggered);
    end
    feed(8'd10);
    @(negedge i_clk);
    n_checks++;
    if ({o_triggered, o_trig_addr} !== {1'b1, 4'd10}) begin
      n_fail++;
      $display("FAIL rising_trig: got trig=%b addr=%0d, required trig=1 addr=10",
               o_triggered, o_trig_addr);
    end
    feed_ramp(11, 11);
    wait_drain("rising");
    n_checks++;
    if (last_cyc - first_cyc != DEPTH - 1) begin
      n_fail++;
      $display("FAIL rising_throughput: got span %0d cycles, required %0d",
               last_cyc - first_cyc, DEPTH - 1);
    end
  endtask

  task automatic test_falling();
    apply_reset();
    hs_cnt = 0;
    arm_capture(8'h80, 1'b0);
    for (int i = 0; i < PRETRIG; i++) exp_q.push_back({1'b0, 8'hFF});
    for (int i = 0; i < DEPTH - PRETRIG; i++)
      exp_q.push_back({(i == DEPTH - PRETRIG - 1), 8'(8'h10 + i)});
    repeat (8) feed(8'hFF);
    @(negedge i_clk);
    n_checks++;
    if ({o_armed, o_triggered} !== 2'b10) begin
      n_fail++;
      $display("FAIL falling_early: got armed=%b trig=%b, required armed=1 trig=0",
               o_armed, o_triggered);
    end
    feed(8'h10);
    @(negedge i_clk);
    n_checks++;
    if ({o_triggered, o_trig_addr} !== {1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL falling_trig: got trig=%b addr=%0d, required trig=1 addr=8",
               o_triggered, o_trig_addr);
    end
    feed_ramp(8'h11, 11);
    wait_drain("falling");
  endtask

  task automatic test_wrap();
    apply_reset();
    hs_cnt = 0;
    // Move the write pointer to 13 with a capture that never triggers.
    arm_capture(8'hF0, 1'b1);
    repeat (13) feed(8'h00);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if ({o_armed, o_triggered, o_rd_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL wrap_preload_abort: got armed=%b trig=%b valid=%b, required 000",
               o_armed, o_triggered, o_rd_valid);
    end
    arm_capture(8'd4, 1'b1);
    push_ramp_window(0);
    feed_ramp(0, 5);
    @(negedge i_clk);
    n_checks++;
    if ({o_triggered, o_trig_addr} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL wrap_trig: got trig=%b addr=%0d, required trig=1 addr=1",
               o_triggered, o_trig_addr);
    end
    feed_ramp(5, 11);
    wait_drain("wrap");
  endtask

  task automatic test_force();
    apply_reset();
    hs_cnt = 0;
    arm_capture(8'hF0, 1'b1);
    push_ramp_window(0);
    feed(8'd0);
    i_force_trig = 1'b1;
    feed(8'd1);
    i_force_trig = 1'b0;
    feed(8'd2);
    feed(8'd3);
    @(negedge i_clk);
    n_checks++;
    if ({o_armed, o_triggered} !== 2'b10) begin
      n_fail++;
      $display("FAIL force_early: got armed=%b trig=%b, required armed=1 trig=0",
               o_armed, o_triggered);
    end
    feed(8'd4);
    @(negedge i_clk);
    n_checks++;
    if ({o_triggered, o_trig_addr} !== {1'b1, 4'd4}) begin
      n_fail++;
      $display("FAIL force_trig: got trig=%b addr=%0d, required trig=1 addr=4",
               o_triggered, o_trig_addr);
    end
    feed_ramp(5, 11);
    wait_drain("force");
  endtask

  task automatic test_back_pressure();
    apply_reset();
    hs_cnt = 0;
    rnd_ready = 1;
    arm_capture(8'd10, 1'b1);
    push_ramp_window(6);
    feed_ramp(0, 22);
    wait_drain("backpressure");
    rnd_ready  = 0;
    i_rd_ready = 1'b1;
  endtask

  task automatic test_abort_reset();
    bit got3 = 0;
    apply_reset();
    hs_cnt = 0;
    arm_capture(8'd10, 1'b1);
    feed_ramp(0, 14);
    i_abort = 1'b1;
    feed(8'd14);
    i_abort = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if ({o_armed, o_triggered, o_trig_addr, o_rd_data, o_rd_valid, o_rd_last} !== '0) begin
      n_fail++;
      $display("FAIL abort_post: got armed=%b trig=%b addr=%h data=%h valid=%b last=%b, required 0",
               o_armed, o_triggered, o_trig_addr, o_rd_data, o_rd_valid, o_rd_last);
    end
    // Write pointer now 14, so the trigger sample lands at address 8.
    arm_capture(8'd10, 1'b1);
    push_ramp_window(6);
    feed_ramp(0, 11);
    @(negedge i_clk);
    n_checks++;
    if ({o_triggered, o_trig_addr} !== {1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL rearm_trig: got trig=%b addr=%0d, required trig=1 addr=8",
               o_triggered, o_trig_addr);
    end
    feed_ramp(11, 11);
    for (int c = 0; c < 100 && !got3; c++) begin
      @(negedge i_clk);
      if (hs_cnt >= 3) got3 = 1;
      else tick();
    end
    n_checks++;
    if (!got3) begin
      n_fail++;
      $display("FAIL readout_start: got %0d handshakes, required at least 3", hs_cnt);
    end
    tick();
    i_reset_n = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    n_checks++;
    if ({o_armed, o_triggered, o_trig_addr, o_rd_data, o_rd_valid, o_rd_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_readout: got armed=%b trig=%b addr=%h data=%h valid=%b last=%b, required 0",
               o_armed, o_triggered, o_trig_addr, o_rd_data, o_rd_valid, o_rd_last);
    end
    tick();
    i_reset_n = 1'b1;
    tick();
    hs_cnt = 0;
    arm_capture(8'd10, 1'b1);
    push_ramp_window(6);
    feed_ramp(0, 11);
    @(negedge i_clk);
    n_checks++;
    if ({o_triggered, o_trig_addr} !== {1'b1, 4'd10}) begin
      n_fail++;
      $display("FAIL after_reset_trig: got trig=%b addr=%0d, required trig=1 addr=10",
               o_triggered, o_trig_addr);
    end
    feed_ramp(11, 11);
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_wrap();
    test_force();
    test_back_pressure();
    test_abort_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
